// File: rtl/uart_rx_irq_if.sv
// CPU-side bundle of the UART receiver: interrupt control inputs and received-byte/status outputs.
// The CPU drives the master modport; the receiver implements the slave modport.
interface uart_rx_irq_if;
    logic       intr_en;
    logic       ack;
    logic [7:0] r_data;
    logic       irr;
    logic       irq;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output intr_en, ack,
        input  r_data, irr, irq, frame_err, overrun, busy
    );

    modport slave (
        input  intr_en, ack,
        output r_data, irr, irq, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_irq.sv
// 8N1 UART receiver with an interrupt-request register for the CPU.
// It latches complete bytes and flags framing and overrun errors until the CPU acknowledges them.
module uart_rx_irq #(
    parameter int WAIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rx,
    uart_rx_irq_if.slave  bus
);

    localparam int CNT_W = $clog2(WAIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(WAIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(WAIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_p0, rx_p1;
    logic             sync_rx;
    logic             stop_ok, stop_bad;

    logic [7:0]       r_data_q;
    logic             irr_q, frame_err_q, overrun_q;

    // Input synchronizer stages; the line idles high, so the flops reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= uart_rx;
            rx_p1 <= rx_p0;
        end
    end

    assign sync_rx = rx_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync_rx) state_d = START;
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = sync_rx;
                    stop_bad = !sync_rx;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A completing byte beats a coincident ack; ack still suppresses overrun and clears frame_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_q    <= '0;
            irr_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (stop_ok) begin
            r_data_q    <= shift_q;
            irr_q       <= 1'b1;
            overrun_q   <= bus.ack ? 1'b0 : (overrun_q | irr_q);
            frame_err_q <= bus.ack ? 1'b0 : frame_err_q;
        end else if (stop_bad) begin
            frame_err_q <= 1'b1;
            if (bus.ack) begin
                irr_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
        end else if (bus.ack) begin
            irr_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end
    end

    assign bus.r_data    = r_data_q;
    assign bus.irr       = irr_q;
    assign bus.irq       = irr_q & bus.intr_en;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_irq.sv
// Bench for uart_rx_irq at WAIT=8: frames are driven on the negative edge, and the expected
// register state is queued by a reference model and popped against the DUT.
module tb_uart_rx_irq;

    localparam int W         = 8;
    localparam int FRAME     = 10 * W;
    localparam int STOP_EDGE = 2 + W / 2 + 9 * W;

    typedef struct packed {
        logic [7:0] rd;
        logic       irr;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic uart_rx;

    uart_rx_irq_if bus();

    uart_rx_irq #(.WAIT(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t m;
    exp_t sb[$];
    exp_t e;

    function automatic logic [10:0] observed();
        return {bus.r_data, bus.irr, bus.frame_err, bus.overrun};
    endfunction

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives n_edges bit-times of a frame; a complete frame also updates the model and queues it.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int ack_edge, input int n_edges);
        logic [9:0] fr;
        logic       ack_hit;
        fr = {stop, b, 1'b0};
        ack_hit = (ack_edge == STOP_EDGE);
        for (int i = 0; i < n_edges; i++) begin
            @(negedge clk);
            uart_rx = fr[i / W];
            bus.ack = (i == ack_edge);
        end
        bus.ack = 1'b0;
        if (n_edges == FRAME) begin
            if (stop) begin
                m.ov  = ack_hit ? 1'b0 : (m.ov | m.irr);
                m.fe  = ack_hit ? 1'b0 : m.fe;
                m.irr = 1'b1;
                m.rd  = b;
            end else begin
                m.fe = 1'b1;
                if (ack_hit) begin
                    m.irr = 1'b0;
                    m.ov  = 1'b0;
                end
            end
            sb.push_back(m);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        m.irr = 1'b0;
        m.fe  = 1'b0;
        m.ov  = 1'b0;
        sb.push_back(m);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        uart_rx = 1'b1;
        bus.intr_en = 1'b0;
        bus.ack = 1'b0;
        m = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (observed() !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected %h", observed(), 11'h0);
        end
        n_checks++;
        if ({bus.busy, bus.irq} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy_irq: got %b expected 00", {bus.busy, bus.irq});
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_rx_basic();
        drive_frame(8'h8F, 1'b1, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL rx_8F: got %h expected %h", observed(), e);
        end
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_disabled: got %b expected 0", bus.irq);
        end
        bus.intr_en = 1'b1;
        #1;
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_enabled: got %b expected 1", bus.irq);
        end
        bus.intr_en = 1'b0;
        idle(2 * W);
    endtask

    task automatic test_ack_overrun();
        ack_pulse();
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL ack_clears_irr: got %h expected %h", observed(), e);
        end
        drive_frame(8'h3C, 1'b1, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL rx_3C: got %h expected %h", observed(), e);
        end
        idle(2 * W);
        drive_frame(8'h55, 1'b1, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL rx_55_overrun: got %h expected %h", observed(), e);
        end
        idle(2 * W);
        ack_pulse();
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL ack_clears_overrun: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_frame_err();
        drive_frame(8'hA5, 1'b0, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL frame_err_A5: got %h expected %h", observed(), e);
        end
        idle(2 * W);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_idle_busy: got %b expected 0", bus.busy);
        end
        ack_pulse();
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL ack_clears_frame_err: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_glitch();
        repeat (2) begin
            @(negedge clk);
            uart_rx = 1'b0;
        end
        @(negedge clk);
        uart_rx = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_start_seen: got %b expected 1", bus.busy);
        end
        repeat (W) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_back_idle: got %b expected 0", bus.busy);
        end
        sb.push_back(m);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL glitch_flags: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_mid_reset();
        drive_frame(8'h81, 1'b1, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL rx_81: got %h expected %h", observed(), e);
        end
        idle(2 * W);
        drive_frame(8'hF0, 1'b1, -1, 5 * W + 4);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_frame: got %b expected 1", bus.busy);
        end
        #1 reset = 1'b0;
        #1;
        m = '0;
        n_checks++;
        if ({observed(), bus.busy} !== 12'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", {observed(), bus.busy}, 12'h0);
        end
        uart_rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        idle(2 * W);
        drive_frame(8'h12, 1'b1, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL rx_12_after_reset: got %h expected %h", observed(), e);
        end
        idle(2 * W);
    endtask

    task automatic test_back_to_back();
        ack_pulse();
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL b2b_pre_ack: got %h expected %h", observed(), e);
        end
        idle(W);
        drive_frame(8'h01, 1'b1, -1, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL b2b_rx_01: got %h expected %h", observed(), e);
        end
        drive_frame(8'h02, 1'b1, STOP_EDGE, FRAME);
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL b2b_rx_02_ack_race: got %h expected %h", observed(), e);
        end
        idle(2 * W);
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_ack_overrun();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
